// File: rtl/code_pkg.sv
// Shared types and constants for the player-1 code entry stage and the player-2 compare stage.
package code_pkg;

   localparam int DEPTH      = 32;
   localparam int SYMS       = 5;
   localparam int SYM_W      = 2;
   localparam int WORD_W     = 10;
   localparam int DASH_TICKS = 2;
   localparam int ADDR_W     = 5;
   localparam int CNT_W      = 6;

   localparam logic [SYM_W-1:0] SYM_EMPTY = 2'b00;
   localparam logic [SYM_W-1:0] SYM_DOT   = 2'b01;
   localparam logic [SYM_W-1:0] SYM_DASH  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_PRESSING,
      ST_COMMIT,
      ST_FINISHED
   } code_state_t;

   // Symbols are left-justified: symbol 0 occupies the top pair of the word.
   function automatic logic [WORD_W-1:0] pack_sym(input logic [WORD_W-1:0] word,
                                                   input logic [2:0]        idx,
                                                   input logic [SYM_W-1:0]  sym);
      logic [WORD_W-1:0] w;
      w = word;
      w[WORD_W - 1 - SYM_W * int'(idx) -: SYM_W] = sym;
      return w;
   endfunction

endpackage

// File: rtl/code_recorder_if.sv
// Write port from the code entry stage into the 32x10 code store.
interface code_recorder_if;
   import code_pkg::*;

   // wr_en is a one-cycle valid strobe with no ready: the store always accepts,
   // capturing wr_addr/wr_data at the rising edge that ends the strobe cycle.
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [WORD_W-1:0]   wr_data;

   modport master (output wr_en, output wr_addr, output wr_data);
   modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/code_recorder_press_timer.sv
// Measures how long the symbol key is held and classifies the press as dot or dash.
module press_timer
   import code_pkg::*;
(
   input  logic             clock_1hz,
   input  logic             resetn,
   input  logic             start,
   input  logic             pressing,
   input  logic             key_n,
   output logic             sym_valid,
   output logic [SYM_W-1:0] sym_code
);

   localparam logic [1:0] DASH_LEN = 2'(DASH_TICKS);

   logic [1:0] press_len;

   always_ff @(posedge clock_1hz) begin
      if (!resetn) begin
         press_len <= 2'd0;
      end else if (start) begin
         press_len <= 2'd1;
      end else if (pressing) begin
         if (!key_n && press_len != 2'd3) begin
            press_len <= press_len + 2'd1;
         end
      end else begin
         press_len <= 2'd0;
      end
   end

   assign sym_valid = pressing && key_n;
   assign sym_code  = (press_len >= DASH_LEN) ? SYM_DASH : SYM_DOT;

endmodule

// File: rtl/code_recorder.sv
// Player-1 code entry: packs dot/dash presses into 10-bit words and writes them to the code store.
// Optional: CODE_RECORDER_AUTOCOMMIT_EN commits a word as soon as its fifth symbol lands.
module code_recorder
   import code_pkg::*;
(
   input  logic               clock_1hz,
   input  logic               resetn,
   input  logic               enable,
   input  logic               key_n,
   input  logic               next_n,
   input  logic               done_n,
   code_recorder_if.master    wr,
   output logic [CNT_W-1:0]   word_count,
   output logic [2:0]         sym_count,
   output logic               full,
   output logic               finished,
   output logic               overflow,
   output code_state_t        dbg_state
);

   code_state_t       state, state_next;
   logic              next_prev, done_prev;
   logic              next_fall, done_fall;
   logic [WORD_W-1:0] word;
   logic              done_pend;

   logic              start, pressing, ins_sym, drop_sym;
   logic              commit_wr, commit_drop, clr_word, set_pend;
   logic              sym_valid;
   logic [SYM_W-1:0]  sym_code;

   assign next_fall = next_prev && !next_n;
   assign done_fall = done_prev && !done_n;
   assign pressing  = (state == ST_PRESSING);

   press_timer u_press_timer (
      .clock_1hz (clock_1hz),
      .resetn    (resetn),
      .start     (start),
      .pressing  (pressing),
      .key_n     (key_n),
      .sym_valid (sym_valid),
      .sym_code  (sym_code)
   );

   always_ff @(posedge clock_1hz) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next  = state;
      start       = 1'b0;
      ins_sym     = 1'b0;
      drop_sym    = 1'b0;
      commit_wr   = 1'b0;
      commit_drop = 1'b0;
      clr_word    = 1'b0;
      set_pend    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) state_next = ST_ARMED;
         end
         ST_ARMED: begin
            if (!enable) begin
               state_next = ST_IDLE;
               clr_word   = 1'b1;
            end else if (!key_n) begin
               state_next = ST_PRESSING;
               start      = 1'b1;
            end else if (done_fall) begin
               if (sym_count != 3'd0) begin
                  state_next = ST_COMMIT;
                  set_pend   = 1'b1;
               end else begin
                  state_next = ST_FINISHED;
               end
            end else if (next_fall && sym_count != 3'd0) begin
               state_next = ST_COMMIT;
            end
         end
         ST_PRESSING: begin
            if (!enable) begin
               state_next = ST_IDLE;
               clr_word   = 1'b1;
            end else if (sym_valid) begin
               state_next = ST_ARMED;
               if (sym_count < 3'(SYMS)) begin
                  ins_sym = 1'b1;
`ifdef CODE_RECORDER_AUTOCOMMIT_EN
                  if (sym_count == 3'(SYMS - 1)) state_next = ST_COMMIT;
`endif
               end else begin
                  drop_sym = 1'b1;
               end
            end
         end
         ST_COMMIT: begin
            clr_word    = 1'b1;
            commit_wr   = !full;
            commit_drop = full;
            state_next  = done_pend ? ST_FINISHED : ST_ARMED;
         end
         ST_FINISHED: begin
            state_next = ST_FINISHED;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_1hz) begin
      if (!resetn) begin
         next_prev  <= 1'b1;
         done_prev  <= 1'b1;
         word       <= '0;
         sym_count  <= 3'd0;
         word_count <= '0;
         overflow   <= 1'b0;
         done_pend  <= 1'b0;
      end else begin
         next_prev <= next_n;
         done_prev <= done_n;
         if (clr_word) begin
            word      <= '0;
            sym_count <= 3'd0;
         end else if (ins_sym) begin
            word      <= pack_sym(word, sym_count, sym_code);
            sym_count <= sym_count + 3'd1;
         end
         if (commit_wr) word_count <= word_count + 6'd1;
         if (drop_sym || commit_drop) overflow <= 1'b1;
         if (set_pend) done_pend <= 1'b1;
         else if (state == ST_COMMIT) done_pend <= 1'b0;
      end
   end

   // Gating with resetn keeps a reset that lands mid-commit from completing the write.
   assign wr.wr_en   = commit_wr && resetn;
   assign wr.wr_addr = word_count[ADDR_W-1:0];
   assign wr.wr_data = word;

   assign full      = (word_count == 6'(DEPTH));
   assign finished  = (state == ST_FINISHED);
   assign dbg_state = state;

endmodule

// File: tb/tb_code_recorder.sv
// Self-checking bench for code_recorder: table vectors, corner sequences and random words vs. a model.
module tb_code_recorder;
  import code_pkg::*;

  logic              clock_1hz = 1'b0;
  logic              resetn, enable, key_n, next_n, done_n;
  logic [CNT_W-1:0]  word_count;
  logic [2:0]        sym_count;
  logic              full, finished, overflow;
  code_state_t       dbg_state;

  code_recorder_if wr_if();

  code_recorder dut (
    .clock_1hz  (clock_1hz),
    .resetn     (resetn),
    .enable     (enable),
    .key_n      (key_n),
    .next_n     (next_n),
    .done_n     (done_n),
    .wr         (wr_if),
    .word_count (word_count),
    .sym_count  (sym_count),
    .full       (full),
    .finished   (finished),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clock_1hz = ~clock_1hz;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // reference model: symbol list of the open word, counters, sticky flags
  int               m_syms[$];
  int               m_wc;
  bit               m_ovf, m_fin;
  logic [14:0]      exp_q[$];
  logic [WORD_W-1:0] last_wr_data;

  task automatic m_clear();
    m_syms.delete();
    m_wc  = 0;
    m_ovf = 0;
    m_fin = 0;
  endtask

  task automatic m_commit();
    int w;
    if (m_syms.size() == 0) return;
    w = 0;
    for (int i = 0; i < m_syms.size(); i++) w = w + m_syms[i] * (1 << (8 - 2 * i));
    if (m_wc < DEPTH) begin
      exp_q.push_back({m_wc[4:0], w[9:0]});
      m_wc++;
    end else begin
      m_ovf = 1;
    end
    m_syms.delete();
  endtask

  task automatic m_press(input int len);
    if (m_fin) return;
    if (m_syms.size() < SYMS) begin
      m_syms.push_back(len >= DASH_TICKS ? 2 : 1);
`ifdef CODE_RECORDER_AUTOCOMMIT_EN
      if (m_syms.size() == SYMS) m_commit();
`endif
    end else begin
      m_ovf = 1;
    end
  endtask

  // scoreboard: every write strobe must match the head of exp_q
  always @(negedge clock_1hz) begin
    if (wr_if.wr_en === 1'b1) begin
      last_wr_data = wr_if.wr_data;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {17'd0, wr_if.wr_addr, wr_if.wr_data}, 32'h7fff_ffff);
      end else begin
        logic [14:0] e;
        e = exp_q.pop_front();
        check("write_addr_data", {17'd0, wr_if.wr_addr, wr_if.wr_data}, {17'd0, e});
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clock_1hz);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; enable = 1'b0; key_n = 1'b1; next_n = 1'b1; done_n = 1'b1;
    tick(); tick();
    resetn = 1'b1;
    m_clear();
    exp_q.delete();
  endtask

  task automatic start();
    enable = 1'b1;
    tick();
  endtask

  task automatic press(input int len);
    m_press(len);
    key_n = 1'b0;
    repeat (len) tick();
    key_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic commit();
    if (!m_fin) m_commit();
    next_n = 1'b0;
    tick();
    next_n = 1'b1;
    tick();
  endtask

  task automatic done();
    if (!m_fin) begin
      m_commit();
      m_fin = 1;
    end
    done_n = 1'b0;
    tick();
    done_n = 1'b1;
    tick();
  endtask

  task automatic check_state(input string tag);
    check({tag, "/word_count"}, word_count, m_wc);
    check({tag, "/sym_count"},  sym_count, m_syms.size());
    check({tag, "/full"},       full, (m_wc == DEPTH));
    check({tag, "/finished"},   finished, m_fin);
    check({tag, "/overflow"},   overflow, m_ovf);
    check({tag, "/writes_seen"}, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/wr_en"},      wr_if.wr_en, 0);
    check({tag, "/wr_addr"},    wr_if.wr_addr, 0);
    check({tag, "/wr_data"},    wr_if.wr_data, 0);
    check({tag, "/word_count"}, word_count, 0);
    check({tag, "/sym_count"},  sym_count, 0);
    check({tag, "/full"},       full, 0);
    check({tag, "/finished"},   finished, 0);
    check({tag, "/overflow"},   overflow, 0);
    check({tag, "/state"},      dbg_state, ST_IDLE);
  endtask

  typedef struct packed {
    logic [2:0]       n;
    logic [4:0][2:0]  lens;
    logic [9:0]       exp_word;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{n: 3'd2, lens: {3'd0, 3'd0, 3'd0, 3'd3, 3'd1}, exp_word: 10'b01_10_00_00_00};
    vecs[1] = '{n: 3'd5, lens: {3'd1, 3'd1, 3'd1, 3'd1, 3'd1}, exp_word: 10'b01_01_01_01_01};
    vecs[2] = '{n: 3'd3, lens: {3'd0, 3'd0, 3'd4, 3'd1, 3'd2}, exp_word: 10'b10_01_10_00_00};
    vecs[3] = '{n: 3'd1, lens: {3'd0, 3'd0, 3'd0, 3'd0, 3'd2}, exp_word: 10'b10_00_00_00_00};
    vecs[4] = '{n: 3'd4, lens: {3'd0, 3'd2, 3'd1, 3'd2, 3'd1}, exp_word: 10'b01_10_01_10_00};

    do_reset();
    check_all_zero("reset");
    start();
    check("armed_state", dbg_state, ST_ARMED);

    // table-driven single words
    for (int v = 0; v < 5; v++) begin
      last_wr_data = 10'h3ff;
      for (int i = 0; i < int'(vecs[v].n); i++) press(int'(vecs[v].lens[i]));
      commit();
      check($sformatf("vec%0d/wr_data", v), last_wr_data, vecs[v].exp_word);
      check_state($sformatf("vec%0d", v));
    end

    // empty commit is ignored
    commit();
    check("empty_commit/word_count", word_count, 5);
    check_state("empty_commit");

    // sixth dot
    last_wr_data = 10'h3ff;
    for (int i = 0; i < 6; i++) press(1);
`ifdef CODE_RECORDER_AUTOCOMMIT_EN
    check("sixth/auto_wr_data", last_wr_data, 10'b01_01_01_01_01);
    check("sixth/sym_count", sym_count, 1);
    check("sixth/overflow", overflow, 0);
`else
    check("sixth/sym_count", sym_count, 5);
    check("sixth/overflow", overflow, 1);
`endif
    commit();
`ifndef CODE_RECORDER_AUTOCOMMIT_EN
    check("sixth/wr_data", last_wr_data, 10'b01_01_01_01_01);
`endif
    check_state("sixth");

    // random words against the model
    for (int w = 0; w < 10; w++) begin
      int n;
      n = $urandom_range(0, 6);
      for (int j = 0; j < n; j++) press($urandom_range(1, 4));
      commit();
      check_state($sformatf("rand%0d", w));
    end

    // fill the store, then one more commit
    do_reset();
    start();
    for (int i = 0; i < DEPTH; i++) begin
      press($urandom_range(1, 3));
      commit();
    end
    check("fill/full", full, 1);
    check("fill/overflow_before", overflow, 0);
    check("fill/wr_addr_wrap", wr_if.wr_addr, 0);
    press(1);
    commit();
    check("fill/overflow_after", overflow, 1);
    check_state("fill");

    // done with two symbols pending: write then finished; later presses ignored
    do_reset();
    start();
    last_wr_data = 10'h3ff;
    press(1);
    press(3);
    done();
    check("done/wr_data", last_wr_data, 10'b01_10_00_00_00);
    check("done/state", dbg_state, ST_FINISHED);
    check_state("done");
    press(2);
    commit();
    check_state("done_sticky");

    // done with nothing pending: straight to finished, no write
    do_reset();
    start();
    done();
    check_state("done_empty");

    // enable drops mid-press: partial word discarded, word_count kept
    do_reset();
    start();
    press(1);
    commit();
    press(2);
    key_n = 1'b0;
    tick();
    check("drop_en/pressing", dbg_state, ST_PRESSING);
    enable = 1'b0;
    tick();
    key_n = 1'b1;
    m_syms.delete();
    check("drop_en/state", dbg_state, ST_IDLE);
    check_state("drop_en");

    // reset lands during COMMIT: no write completes
    do_reset();
    start();
    press(2);
    next_n = 1'b0;
    tick();
    next_n = 1'b1;
    check("rst_commit/in_commit", dbg_state, ST_COMMIT);
    resetn = 1'b0;
    #1;
    check("rst_commit/wr_en_gated", wr_if.wr_en, 0);
    tick();
    m_clear();
    check_all_zero("rst_commit");
    resetn = 1'b1;
    tick();
    check_state("rst_commit");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
